// File: rtl/pwm_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_unit_if
// Description : Host-side control/status bundle for the pwm_unit channel.
// Revision    : 1.0 - initial release
// ============================================================================

interface pwm_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pwm_value;
    logic [WIDTH-1:0] pwm_range;
    logic             pwm_en;
    logic             pwm_period;
    logic             pwm_out;

    modport master (
        output pwm_value,
        output pwm_range,
        output pwm_en,
        input  pwm_period,
        input  pwm_out
    );

    modport slave (
        input  pwm_value,
        input  pwm_range,
        input  pwm_en,
        output pwm_period,
        output pwm_out
    );
endinterface

`default_nettype wire

// File: rtl/pwm_unit.sv
`default_nettype none
// ============================================================================
// Module      : pwm_unit
// Description : Single-channel PWM with shadowed duty/period, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================

module pwm_unit #(
    parameter int WIDTH = 8
) (
    input  wire logic    pwm_clk,
    input  wire logic    pwm_reset,
    pwm_unit_if.slave    bus
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_RUN  = 1'b1;
    localparam logic [WIDTH-1:0] c_ZERO    = '0;
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_value_sh;
    logic [WIDTH-1:0] r_range_sh;
    logic             r_out;
    logic             r_period;

    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_value_sh_next;
    logic [WIDTH-1:0] w_range_sh_next;
    logic             w_out_next;
    logic             w_period_next;
    logic             w_run_next;
    logic             w_wrap;

    // A zero range behaves as a one-slot period that wraps on every cycle.
    assign w_wrap = (r_range_sh == c_ZERO) || (r_cnt == (r_range_sh - c_ONE));

    always_ff @(posedge pwm_clk) begin
        if (!pwm_reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.pwm_en)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (!bus.pwm_en) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they line up with cnt.
    always_comb begin
        w_cnt_next      = r_cnt;
        w_value_sh_next = r_value_sh;
        w_range_sh_next = r_range_sh;
        w_run_next      = (w_state_next == c_ST_RUN);

        if (!w_run_next || (r_state == c_ST_IDLE) || w_wrap) begin
            w_cnt_next      = c_ZERO;
            w_value_sh_next = bus.pwm_value;
            w_range_sh_next = bus.pwm_range;
        end else begin
            w_cnt_next      = r_cnt + c_ONE;
        end

        w_out_next    = w_run_next
                     && (w_range_sh_next != c_ZERO)
                     && (w_cnt_next < w_value_sh_next);
        w_period_next = w_run_next
                     && ((w_range_sh_next == c_ZERO)
                      || (w_cnt_next == (w_range_sh_next - c_ONE)));
    end

    always_ff @(posedge pwm_clk) begin
        if (!pwm_reset) begin
            r_cnt      <= c_ZERO;
            r_value_sh <= c_ZERO;
            r_range_sh <= c_ZERO;
            r_out      <= 1'b0;
            r_period   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_value_sh <= w_value_sh_next;
            r_range_sh <= w_range_sh_next;
            r_out      <= w_out_next;
            r_period   <= w_period_next;
        end
    end

    assign bus.pwm_out    = r_out;
    assign bus.pwm_period = r_period;

endmodule

`default_nettype wire

// File: tb/tb_pwm_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_unit
// Description : Directed + randomized checks of pwm_unit against a period-queue model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pwm_unit;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_unit_if #(.WIDTH(WIDTH)) bus ();

    pwm_unit #(.WIDTH(WIDTH)) dut (
        .pwm_clk   (clk),
        .pwm_reset (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hi_cnt   = 0;
    int per_cnt  = 0;

    // Each entry is {out, period} for one cycle of the current period.
    bit [1:0] exp_q[$];
    bit       exp_out;
    bit       exp_per;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit e, input int v, input int g);
        bit [1:0] ent;
        if (!r || !e) begin
            exp_q.delete();
            exp_out = 1'b0;
            exp_per = 1'b0;
        end else begin
            if (exp_q.size() == 0) begin
                if (g == 0) begin
                    exp_q.push_back(2'b01);
                end else begin
                    for (int i = 0; i < g; i++)
                        exp_q.push_back({(i < v), (i == g - 1)});
                end
            end
            ent     = exp_q.pop_front();
            exp_out = ent[1];
            exp_per = ent[0];
        end
    endtask

    task automatic step(input bit r, input bit e, input int v, input int g, input string tag);
        rst_n         = r;
        bus.pwm_en    = e;
        bus.pwm_value = v[WIDTH-1:0];
        bus.pwm_range = g[WIDTH-1:0];
        @(posedge clk);
        model(r, e, v, g);
        #1;
        check({tag, "_out"}, {31'd0, bus.pwm_out},    {31'd0, exp_out});
        check({tag, "_per"}, {31'd0, bus.pwm_period}, {31'd0, exp_per});
        hi_cnt  += int'(bus.pwm_out);
        per_cnt += int'(bus.pwm_period);
    endtask

    task automatic run(input int n, input bit e, input int v, input int g, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, e, v, g, tag);
    endtask

    task automatic clr();
        hi_cnt  = 0;
        per_cnt = 0;
    endtask

    initial begin
        bus.pwm_en    = 1'b1;
        bus.pwm_value = 8'd3;
        bus.pwm_range = 8'd10;

        // Reset held with enable asserted
        clr();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3, 10, "rst");
        check("rst_hi", hi_cnt, 0);
        check("rst_per", per_cnt, 0);

        // Basic duty: three full periods of 3-high / 7-low
        run(1, 1'b0, 3, 10, "idle");
        clr(); run(30, 1'b1, 3, 10, "basic");
        check("basic_hi", hi_cnt, 9);
        check("basic_per", per_cnt, 3);

        // Extremes
        run(1, 1'b0, 0, 10, "idle");
        clr(); run(20, 1'b1, 0, 10, "v0");
        check("v0_hi", hi_cnt, 0);
        check("v0_per", per_cnt, 2);
        run(1, 1'b0, 10, 10, "idle");
        clr(); run(20, 1'b1, 10, 10, "v10");
        check("v10_hi", hi_cnt, 20);
        check("v10_per", per_cnt, 2);
        run(1, 1'b0, 12, 10, "idle");
        clr(); run(20, 1'b1, 12, 10, "v12");
        check("v12_hi", hi_cnt, 20);
        check("v12_per", per_cnt, 2);

        // Mid-period duty change applies from the next boundary
        run(1, 1'b0, 3, 10, "idle");
        clr(); run(5, 1'b1, 3, 10, "mid"); run(15, 1'b1, 7, 10, "mid");
        check("mid_hi", hi_cnt, 10);
        check("mid_per", per_cnt, 2);

        // Mid-period range change 10 -> 4
        run(1, 1'b0, 3, 10, "idle");
        clr(); run(5, 1'b1, 3, 10, "rng"); run(11, 1'b1, 3, 4, "rng");
        check("rng_hi", hi_cnt, 8);
        check("rng_per", per_cnt, 2);

        // Enable toggling: drop at cycle 2, re-raise with new inputs
        run(1, 1'b0, 3, 10, "idle");
        run(2, 1'b1, 3, 10, "tog");
        clr(); run(1, 1'b0, 5, 10, "tog_off");
        check("tog_off_hi", hi_cnt, 0);
        clr(); run(10, 1'b1, 5, 10, "tog_on");
        check("tog_hi", hi_cnt, 5);
        check("tog_per", per_cnt, 1);

        // Degenerate ranges
        run(1, 1'b0, 5, 0, "idle");
        clr(); run(10, 1'b1, 5, 0, "r0");
        check("r0_hi", hi_cnt, 0);
        check("r0_per", per_cnt, 10);
        run(1, 1'b0, 1, 1, "idle");
        clr(); run(10, 1'b1, 1, 1, "r1");
        check("r1_hi", hi_cnt, 10);
        check("r1_per", per_cnt, 10);

        // Randomized sequences including resets and enable drops
        begin
            int v = 3;
            int g = 10;
            bit e = 1'b1;
            bit r;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 7) == 0) v = int'($urandom_range(0, 16));
                if ($urandom_range(0, 7) == 0)
                    g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(0, 16));
                if ($urandom_range(0, 15) == 0) e = ~e;
                r = ($urandom_range(0, 99) != 0);
                step(r, e, v, g, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
